// File: rtl/ram_pkg.sv
// Timing constants shared by the RAM controller, the refresh timer and their benches,
// so every block agrees on refresh cadence and urgency thresholds.
package ram_pkg;

    localparam int REF_INTERVAL_DEF = 250;
    localparam int URGENT_DELAY_DEF = 64;
    localparam int MAX_PENDING_DEF  = 3;

endpackage : ram_pkg

// File: rtl/ref_timer.sv
// DRAM refresh initiator: schedules a refresh every REF_INTERVAL clocks, tracks the
// backlog of owed refreshes against RefAck, and escalates to RefUrgent as requests age.
module ref_timer
    import ram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int URGENT_DELAY = URGENT_DELAY_DEF,
    parameter int MAX_PENDING  = MAX_PENDING_DEF
) (
    input  logic                             CLK,
    input  logic                             Reset,
    input  logic                             RefAck,
    output logic                             RefReq,
    output logic                             RefUrgent,
    output logic [$clog2(MAX_PENDING+1)-1:0] Pending,
    output logic                             Overrun
);

    localparam int CW = $clog2(REF_INTERVAL);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int AW = $clog2(URGENT_DELAY + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
    localparam logic [AW-1:0] AGE_MAX  = AW'(URGENT_DELAY);

    logic [CW-1:0] r_cnt;
    logic          r_ackq;
    logic [PW-1:0] r_pending;
    logic [AW-1:0] r_age;
    logic          r_req;
    logic          r_urg;
    logic          r_ovr;

    logic [CW-1:0] w_cnt_next;
    logic [PW-1:0] w_pend_next;
    logic [AW-1:0] w_age_next;
    logic          w_tick;
    logic          w_ack;
    logic          w_req_next;
    logic          w_urg_next;
    logic          w_ovr_next;

    always_comb begin
        w_tick      = (r_cnt == CNT_LAST);
        w_cnt_next  = w_tick ? '0 : r_cnt + 1'b1;
        w_ack       = RefAck & ~r_ackq;
        w_pend_next = r_pending;
        w_ovr_next  = r_ovr;

        // A tick and an ack on the same edge cancel, even at the saturation limit.
        if (w_tick && !w_ack) begin
            if (r_pending == PEND_MAX) begin
                w_ovr_next = 1'b1;
            end else begin
                w_pend_next = r_pending + 1'b1;
            end
        end else if (w_ack && !w_tick && (r_pending != '0)) begin
            w_pend_next = r_pending - 1'b1;
        end

        // Age restarts whenever the oldest owed refresh changes identity.
        if ((w_pend_next == '0) || w_ack || (r_pending == '0)) begin
            w_age_next = '0;
        end else if (r_age == AGE_MAX) begin
            w_age_next = r_age;
        end else begin
            w_age_next = r_age + 1'b1;
        end

        w_req_next = (w_pend_next != '0);
        w_urg_next = w_req_next && ((w_pend_next == PEND_MAX) || (w_age_next == AGE_MAX));
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_ackq    <= 1'b0;
            r_pending <= '0;
            r_age     <= '0;
            r_req     <= 1'b0;
            r_urg     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_ackq    <= RefAck;
            r_pending <= w_pend_next;
            r_age     <= w_age_next;
            r_req     <= w_req_next;
            r_urg     <= w_urg_next;
            r_ovr     <= w_ovr_next;
        end
    end

    assign RefReq    = r_req;
    assign RefUrgent = r_urg;
    assign Pending   = r_pending;
    assign Overrun   = r_ovr;

endmodule : ref_timer

// File: tb/tb_ref_timer.sv
// Bench for ref_timer: directed table and corner sequences plus random RefAck/Reset
// traffic, all checked against an edge-counting reference model.
module tb_ref_timer;

    localparam int RI = 8;
    localparam int UD = 5;
    localparam int MP = 3;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       RefAck = 1'b0;
    logic       RefReq;
    logic       RefUrgent;
    logic [1:0] Pending;
    logic       Overrun;

    int total = 0;
    int bad = 0;

    // Reference model: edges since reset release, edge of last age restart.
    int m_n = 0;
    int m_pend = 0;
    int m_prev = 0;
    int m_clr = 0;
    int m_ovr = 0;
    int m_req = 0;
    int m_urg = 0;

    typedef struct {
        int   edge_n;
        logic req;
        logic urg;
        int   pend;
        logic ovr;
    } vec_t;

    vec_t tbl[10];

    ref_timer #(
        .REF_INTERVAL(RI),
        .URGENT_DELAY(UD),
        .MAX_PENDING (MP)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .RefAck   (RefAck),
        .RefReq   (RefReq),
        .RefUrgent(RefUrgent),
        .Pending  (Pending),
        .Overrun  (Overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic a);
        int tick;
        int ack;
        int old;
        int age;
        if (r) begin
            m_n = 0; m_pend = 0; m_prev = 0; m_clr = 0; m_ovr = 0;
            m_req = 0; m_urg = 0;
        end else begin
            m_n++;
            tick = (m_n % RI == 0) ? 1 : 0;
            ack = (a && m_prev == 0) ? 1 : 0;
            m_prev = a ? 1 : 0;
            old = m_pend;
            if (tick == 1 && ack == 0) begin
                if (m_pend == MP) m_ovr = 1;
                else m_pend++;
            end else if (ack == 1 && tick == 0 && m_pend > 0) begin
                m_pend--;
            end
            if (m_pend == 0 || ack == 1 || old == 0) m_clr = m_n;
            age = (m_n - m_clr > UD) ? UD : m_n - m_clr;
            m_req = (m_pend != 0) ? 1 : 0;
            m_urg = (m_req == 1 && (m_pend == MP || age == UD)) ? 1 : 0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare against the model.
    task automatic cyc(input logic r, input logic a);
        Reset = r;
        RefAck = a;
        @(posedge CLK);
        model_edge(r, a);
        #1;
        chk("model_req", int'(RefReq), m_req);
        chk("model_urg", int'(RefUrgent), m_urg);
        chk("model_pend", int'(Pending), m_pend);
        chk("model_ovr", int'(Overrun), m_ovr);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic outs(input string nm, input int req, input int urg, input int pend, input int ovr);
        chk({nm, "_req"}, int'(RefReq), req);
        chk({nm, "_urg"}, int'(RefUrgent), urg);
        chk({nm, "_pend"}, int'(Pending), pend);
        chk({nm, "_ovr"}, int'(Overrun), ovr);
    endtask

    initial begin
        int k;
        int p;
        tbl[0] = '{7,  1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{8,  1'b1, 1'b0, 1, 1'b0};
        tbl[2] = '{12, 1'b1, 1'b0, 1, 1'b0};
        tbl[3] = '{13, 1'b1, 1'b1, 1, 1'b0};
        tbl[4] = '{16, 1'b1, 1'b1, 2, 1'b0};
        tbl[5] = '{23, 1'b1, 1'b1, 2, 1'b0};
        tbl[6] = '{24, 1'b1, 1'b1, 3, 1'b0};
        tbl[7] = '{31, 1'b1, 1'b1, 3, 1'b0};
        tbl[8] = '{32, 1'b1, 1'b1, 3, 1'b1};
        tbl[9] = '{40, 1'b1, 1'b1, 3, 1'b1};

        // Reset state, then the unserviced-backlog walk from the table.
        do_reset(3);
        outs("reset", 0, 0, 0, 0);
        k = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc(1'b0, 1'b0);
            if (k < 10 && tbl[k].edge_n == e) begin
                outs($sformatf("tbl%0d", e), int'(tbl[k].req), int'(tbl[k].urg),
                     tbl[k].pend, int'(tbl[k].ovr));
                k++;
            end
        end

        // Single-cycle ack at edge 10 clears the request; next tick at 16.
        do_reset(3);
        for (int e = 1; e <= 16; e++) begin
            cyc(1'b0, (e == 10) ? 1'b1 : 1'b0);
            if (e == 10) outs("ack10", 0, 0, 0, 0);
            if (e == 15) chk("ack10_req15", int'(RefReq), 0);
            if (e == 16) outs("ack10_e16", 1, 0, 1, 0);
        end

        // Ack held for 20 cycles counts once.
        do_reset(3);
        for (int e = 1; e <= 30; e++) begin
            cyc(1'b0, (e >= 9 && e <= 28) ? 1'b1 : 1'b0);
            if (e == 9)  chk("hold_pend9", int'(Pending), 0);
            if (e == 16) chk("hold_pend16", int'(Pending), 1);
            if (e == 24) chk("hold_pend24", int'(Pending), 2);
            if (e == 30) chk("hold_pend30", int'(Pending), 2);
        end

        // Ack coincident with tick at 16: backlog unchanged, age restarts.
        do_reset(3);
        for (int e = 1; e <= 22; e++) begin
            cyc(1'b0, (e == 16) ? 1'b1 : 1'b0);
            if (e == 15) outs("coin15", 1, 1, 1, 0);
            if (e == 16) outs("coin16", 1, 0, 1, 0);
            if (e == 20) chk("coin_urg20", int'(RefUrgent), 0);
            if (e == 21) chk("coin_urg21", int'(RefUrgent), 1);
        end

        // Reset mid-request at edge 20 drops everything; next request 8 edges later.
        do_reset(3);
        for (int e = 1; e <= 19; e++) cyc(1'b0, 1'b0);
        outs("prerst", 1, 1, 2, 0);
        cyc(1'b1, 1'b0);
        outs("midrst", 0, 0, 0, 0);
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 1'b0);
            if (e == 7) chk("rst_req7", int'(RefReq), 0);
            if (e == 8) chk("rst_req8", int'(RefReq), 1);
        end

        // Random traffic with shifting ack density and occasional reset.
        do_reset(2);
        p = 10;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) p = $urandom_range(2, 60);
            cyc(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ref_timer

// File: doc/ref_timer.md
Name: ref_timer

Overview:
- Initiator side of the DRAM refresh handshake: generates RefReq/RefUrgent for the RAM controller and consumes its RefAck.
- Counts CLK cycles and schedules one refresh every REF_INTERVAL clocks.
- Tracks owed (pending) refreshes and escalates to urgent when a request ages or the backlog saturates.
- Sits beside the RAM controller in the CPLD, clocked by the same CLK.

Parameters:
REF_INTERVAL, 250, CLK cycles between refresh ticks (>=2)
URGENT_DELAY, 64, CLK cycles a request may wait before RefUrgent (>=1)
MAX_PENDING, 3, saturation limit of owed refreshes (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
RefAck  in  1  refresh-done indication from RAM controller (level; counted on rising edge)
RefReq  out  1  refresh owed (Pending != 0)
RefUrgent  out  1  refresh must preempt CPU access
Pending  out  clog2(MAX_PENDING+1)  owed-refresh count
Overrun  out  1  sticky: a tick was lost at saturation

Behaviour:
- Reset (sampled on CLK edge) overrides everything. Interval counter=0, Pending=0, age=0, AckQ=0. RefReq=0, RefUrgent=0, Overrun=0.
- Reset mid-request drops all owed refreshes; no output glitch.
- All outputs are registered, computed from next-state values, so they change on the same edge as the state they reflect.
- Interval counter: 0..REF_INTERVAL-1, increments every cycle.
  - tick = (counter == REF_INTERVAL-1); counter then wraps to 0.
  - First tick lands on the REF_INTERVAL-th edge after Reset deasserts.
- Ack detect: AckQ <= RefAck. ack = RefAck & ~AckQ.
  - Acks held for many cycles count once; one ack per rising edge.
- Pending update per edge:
  - tick & ~ack: Pending+1, saturating at MAX_PENDING.
  - ack & ~tick: Pending-1 if Pending>0; ignored when Pending==0.
  - tick & ack: Pending unchanged, including at 0 and at MAX_PENDING.
  - Overrun set when tick & ~ack & Pending==MAX_PENDING; cleared only by Reset.
- RefReq = (Pending_next != 0).
- Age counter: width clog2(URGENT_DELAY+1), saturates at URGENT_DELAY.
  - Cleared to 0 when Pending_next==0, on any counted ack, and on the edge Pending goes 0->1.
  - Otherwise increments while Pending != 0.
- RefUrgent = (Pending_next == MAX_PENDING) | (age_next == URGENT_DELAY), both with Pending_next != 0.
  - Consequence: RefUrgent rises URGENT_DELAY edges after RefReq rises if unserviced.
  - Drops on the edge the ack is counted, unless backlog is still at MAX_PENDING.
- No other state; no combinational path from RefAck to outputs.

Decomposition:
- Shared package ram_pkg holds default constants REF_INTERVAL_DEF, URGENT_DELAY_DEF, MAX_PENDING_DEF, so the RAM controller and bench agree on timing.
- Single flat module; no sub-module warranted (edge detect and saturating counters are a few lines each).

Test Plan (REF_INTERVAL=8, URGENT_DELAY=5, MAX_PENDING=3 unless stated):
1. Reset held 3 edges, then released, RefAck=0 -> RefReq rises on edge 8, Pending=1; RefUrgent rises on edge 13; Overrun=0.
2. RefAck pulsed high 1 cycle at edge 10 -> Pending=0, RefReq and RefUrgent low from edge 10; RefReq rises again at edge 16.
3. RefAck never asserted -> Pending 1,2,3 at edges 8,16,24; RefUrgent high from edge 13; Overrun rises at edge 32; Pending stays 3.
4. RefAck held high for 20 cycles starting edge 9 -> exactly one decrement (Pending 1->0 at 9); ticks at 16 and 24 raise Pending to 1, 2.
5. RefAck rising edge coincident with tick at edge 16, Pending=1 -> Pending stays 1; age cleared, so RefUrgent (if high) drops and re-rises at edge 21.
6. Reset asserted at edge 20 with Pending=2, RefUrgent=1 -> all outputs 0 at edge 20; next RefReq at 8 edges after Reset release.
